// File: rtl/sierpinski_pattern_gen.sv
// Row-state pattern generator: Galois LFSR or rule-90/150/30 automaton streamed over ready/valid,
// with seed loading, frame re-seeding after ROWS rows and all-zero lockup recovery.
module sierpinski_pattern_gen #(
  parameter int unsigned           WIDTH        = 8,
  parameter logic [WIDTH-1:0]      TAPS         = WIDTH'(8'hB8),
  parameter int unsigned           ROWS         = 16,
  parameter logic [WIDTH-1:0]      DEFAULT_SEED = WIDTH'(8'h10)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       mode_i,
  input  logic             run_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_data_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic [7:0]       row_o,
  output logic             frame_done_o,
  output logic             lockup_o
);

  localparam int unsigned RW       = 8;
  localparam bit          WRAP_EN  = (ROWS != 0);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  localparam logic [1:0] MODE_LFSR = 2'b00;
  localparam logic [1:0] MODE_R90  = 2'b01;
  localparam logic [1:0] MODE_R150 = 2'b10;

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [RW-1:0]    row_q, row_d;
  logic             valid_q, valid_d;
  logic             lockup_q, lockup_d;
  logic             frame_done_q, frame_done_d;

  logic             xfer;
  logic [WIDTH-1:0] left_nb, right_nb, rule_next;

  assign xfer = valid_q & out_ready_i;

  // Neighbour views: left_nb[i] = s[i+1], right_nb[i] = s[i-1], edges read 0.
  assign left_nb  = state_q >> 1;
  assign right_nb = state_q << 1;

  always_comb begin
    rule_next = state_q;
    case (mode_i)
      MODE_LFSR: rule_next = left_nb ^ (state_q[0] ? TAPS : '0);
      MODE_R90:  rule_next = left_nb ^ right_nb;
      MODE_R150: rule_next = left_nb ^ state_q ^ right_nb;
      default:   rule_next = left_nb ^ (state_q | right_nb);
    endcase
  end

  // Seed load beats everything; a coincident transfer is consumed without advancing.
  always_comb begin
    state_d      = state_q;
    reload_d     = reload_q;
    row_d        = row_q;
    lockup_d     = lockup_q;
    frame_done_d = 1'b0;
    valid_d      = run_i;
    if (seed_load_i) begin
      state_d  = seed_data_i;
      reload_d = seed_data_i;
      row_d    = '0;
      lockup_d = 1'b0;
    end else if (xfer) begin
      if (WRAP_EN && (row_q == LAST_ROW)) begin
        state_d      = reload_q;
        row_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        row_d = row_q + 8'd1;
        if (state_q == '0) begin
          state_d  = DEFAULT_SEED;
          lockup_d = 1'b1;
        end else begin
          state_d = rule_next;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= DEFAULT_SEED;
      reload_q     <= DEFAULT_SEED;
      row_q        <= '0;
      valid_q      <= 1'b0;
      lockup_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      reload_q     <= reload_d;
      row_q        <= row_d;
      valid_q      <= valid_d;
      lockup_q     <= lockup_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_data_o   = state_q;
  assign out_valid_o  = valid_q;
  assign row_o        = row_q;
  assign frame_done_o = frame_done_q;
  assign lockup_o     = lockup_q;

endmodule
